// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Receive side of a scanned seven-segment HEX bus. Samples the active-low
// segment lines and one-hot digit strobe, waits for a pattern to be stable
// for STABLE_CYCLES samples, then decodes it into a per-digit nibble with
// valid/error flags, an update strobe and a saturating illegal-glyph count.
module seg7_scan_decoder #(
    parameter int DIGITS        = 6,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     dig_valid,
    output logic [DIGITS-1:0]     dig_err,
    output logic                  upd_pulse,
    output logic [IDX_W-1:0]      upd_idx,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        LATCHED = 2'd2
    } state_t;

    localparam logic [3:0] LATCH_AT = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] FULL_CNT = 4'(STABLE_CYCLES);

    // Two-stage sample pipeline: stage 1 is the current sample, stage 2 the previous one
    logic [DIGITS-1:0] sel_reg;
    logic [6:0]        seg_reg;
    logic [DIGITS-1:0] sel_prev_reg;
    logic [6:0]        seg_prev_reg;

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        cnt_reg;
    logic [3:0]        cnt_next;
    logic              latch;

    logic              same;
    logic              onehot;
    logic [3:0]        glyph_nib;
    logic              glyph_ok;
    logic              blank;
    logic [IDX_W-1:0]  sel_idx;

    logic              upd_pulse_reg;
    logic [IDX_W-1:0]  upd_idx_reg;
    logic [7:0]        err_count_reg;
    logic [3:0]        nib_reg   [DIGITS];
    logic [DIGITS-1:0] valid_reg;
    logic [DIGITS-1:0] err_reg;

    // Sample registers keep loading through clear; only reset zeroes them
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sel_reg      <= '0;
            seg_reg      <= '0;
            sel_prev_reg <= '0;
            seg_prev_reg <= '0;
        end else begin
            sel_reg      <= dig_sel;
            seg_reg      <= seg_n;
            sel_prev_reg <= sel_reg;
            seg_prev_reg <= seg_reg;
        end
    end

    assign same   = ({sel_reg, seg_reg} == {sel_prev_reg, seg_prev_reg});
    assign onehot = (sel_reg != '0) && ((sel_reg & (sel_reg - DIGITS'(1))) == '0);

    // Stability FSM state and sample counter
    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: a change always restarts the window; the latch fires on the
    // edge that sees the STABLE_CYCLES-th identical sample
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (onehot) begin
                    state_next = TRACK;
                    cnt_next   = 4'd1;
                end
            end
            TRACK: begin
                if (same) begin
                    if (cnt_reg == LATCH_AT) begin
                        latch      = 1'b1;
                        state_next = LATCHED;
                        cnt_next   = FULL_CNT;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end else if (onehot) begin
                    state_next = TRACK;
                    cnt_next   = 4'd1;
                end else begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            end
            LATCHED: begin
                if (!same) begin
                    if (onehot) begin
                        state_next = TRACK;
                        cnt_next   = 4'd1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Glyph lookup of the current sample (segments listed g..a, active-low)
    always_comb begin
        glyph_nib = 4'h0;
        glyph_ok  = 1'b1;
        case (seg_reg)
            7'h40: glyph_nib = 4'h0;
            7'h79: glyph_nib = 4'h1;
            7'h24: glyph_nib = 4'h2;
            7'h30: glyph_nib = 4'h3;
            7'h19: glyph_nib = 4'h4;
            7'h12: glyph_nib = 4'h5;
            7'h02: glyph_nib = 4'h6;
            7'h78: glyph_nib = 4'h7;
            7'h00: glyph_nib = 4'h8;
            7'h10: glyph_nib = 4'h9;
            7'h08: glyph_nib = 4'hA;
            7'h03: glyph_nib = 4'hB;
            7'h46: glyph_nib = 4'hC;
            7'h21: glyph_nib = 4'hD;
            7'h06: glyph_nib = 4'hE;
            7'h0E: glyph_nib = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    assign blank = (seg_reg == 7'h7F);

    // One-hot to binary index of the strobed digit
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_reg[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Update strobe, last-updated index and saturating illegal-latch counter
    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            upd_pulse_reg <= 1'b0;
            upd_idx_reg   <= '0;
            err_count_reg <= 8'd0;
        end else begin
            upd_pulse_reg <= latch;
            if (latch) begin
                upd_idx_reg <= sel_idx;
                if (!glyph_ok && !blank && (err_count_reg != 8'hFF)) begin
                    err_count_reg <= err_count_reg + 8'd1;
                end
            end
        end
    end

    // Per-digit decoded state; only the strobed digit reacts to a latch
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        // Digit gi nibble and flags
        always_ff @(posedge clock) begin
            if (!resetn || clear) begin
                nib_reg[gi]   <= 4'h0;
                valid_reg[gi] <= 1'b0;
                err_reg[gi]   <= 1'b0;
            end else if (latch && sel_reg[gi]) begin
                if (glyph_ok) begin
                    nib_reg[gi]   <= glyph_nib;
                    valid_reg[gi] <= 1'b1;
                    err_reg[gi]   <= 1'b0;
                end else if (blank) begin
                    nib_reg[gi]   <= 4'h0;
                    valid_reg[gi] <= 1'b0;
                    err_reg[gi]   <= 1'b0;
                end else begin
                    valid_reg[gi] <= 1'b0;
                    err_reg[gi]   <= 1'b1;
                end
            end
        end

        assign hex_out[4*gi +: 4] = nib_reg[gi];
    end

    assign dig_valid = valid_reg;
    assign dig_err   = err_reg;
    assign upd_pulse = upd_pulse_reg;
    assign upd_idx   = upd_idx_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Directed vectors for the scanned seven-segment receiver. Stimulus pushes the
// expected latch result into a queue; a negedge monitor pops it on each
// upd_pulse and compares the latched digit's outputs.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 6;
    localparam int IDX_W  = 3;

    logic                clock = 1'b0;
    logic                resetn;
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   dig_sel;
    logic                clear;
    logic [4*DIGITS-1:0] hex_out;
    logic [DIGITS-1:0]   dig_valid;
    logic [DIGITS-1:0]   dig_err;
    logic                upd_pulse;
    logic [IDX_W-1:0]    upd_idx;
    logic [7:0]          err_count;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .seg_n     (seg_n),
        .dig_sel   (dig_sel),
        .clear     (clear),
        .hex_out   (hex_out),
        .dig_valid (dig_valid),
        .dig_err   (dig_err),
        .upd_pulse (upd_pulse),
        .upd_idx   (upd_idx),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         idx;
        logic [3:0] nib;
        logic       valid;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         vectors    = 0;
    int         miscompares = 0;

    // Hand-written glyph table (g..a, active-low)
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] m_nib [DIGITS];
    logic [7:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_nib[i] = 4'h0;
        m_cnt = 8'd0;
    endtask

    // Compute the expected result of latching seg on digit idx and queue it
    task automatic expect_latch(input int idx, input logic [6:0] seg);
        exp_t e;
        logic found;
        found = 1'b0;
        e.idx = idx;
        for (int g = 0; g < 16; g++) begin
            if (glyph[g] == seg) begin
                found = 1'b1;
                m_nib[idx] = 4'(g);
            end
        end
        if (found) begin
            e.valid = 1'b1; e.err = 1'b0;
        end else if (seg == 7'h7F) begin
            m_nib[idx] = 4'h0;
            e.valid = 1'b0; e.err = 1'b0;
        end else begin
            e.valid = 1'b0; e.err = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        e.nib = m_nib[idx];
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Drive one pattern for n cycles (called at a negedge); report pulses seen
    task automatic hold(input logic [5:0] sel, input logic [6:0] seg, input int n,
                        output int first, output int pulses);
        first  = 0;
        pulses = 0;
        dig_sel = sel;
        seg_n   = seg;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            if (upd_pulse) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
    endtask

    // Monitor: every update strobe must match the oldest queued expectation
    always @(negedge clock) begin
        if (upd_pulse) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: upd_idx=%0d, expected no pulse", upd_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_idx",   32'(upd_idx), 32'(e.idx));
                check("hex_nib",   32'(hex_out[4*e.idx +: 4]), 32'(e.nib));
                check("dig_valid", 32'(dig_valid[e.idx]), 32'(e.valid));
                check("dig_err",   32'(dig_err[e.idx]), 32'(e.err));
                check("err_count", 32'(err_count), 32'(e.cnt));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_hex"},   32'(hex_out), 32'h0);
        check({tag, "_valid"}, 32'(dig_valid), 32'h0);
        check({tag, "_err"},   32'(dig_err), 32'h0);
        check({tag, "_pulse"}, 32'(upd_pulse), 32'h0);
        check({tag, "_idx"},   32'(upd_idx), 32'h0);
        check({tag, "_count"}, 32'(err_count), 32'h0);
    endtask

    logic [6:0] t2_seg [6] = '{7'h40, 7'h78, 7'h08, 7'h03, 7'h06, 7'h0E};

    initial begin
        int first, pulses, waited;
        logic [6:0] s;
        resetn  = 1'b0;
        clear   = 1'b0;
        seg_n   = 7'h7F;
        dig_sel = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        resetn = 1'b1;

        // 1: single digit, latency check
        expect_latch(0, 7'h24);
        hold(6'b000001, 7'h24, 6, first, pulses);
        check("t1_latency", 32'(first), 32'd5);
        check("t1_pulses",  32'(pulses), 32'd1);
        check("t1_hex",     32'(hex_out[3:0]), 32'h2);
        check("t1_valid",   32'(dig_valid), 32'h01);

        // 2: scan all digits, then a too-short hold
        for (int d = 0; d < DIGITS; d++) begin
            expect_latch(d, t2_seg[d]);
            hold(6'(1 << d), t2_seg[d], 5, first, pulses);
        end
        hold(6'b000001, 7'h79, 3, first, pulses);
        hold(6'b000000, 7'h7F, 5, first, pulses);
        check("t2_hex",   32'(hex_out), 32'hFEBA70);
        check("t2_valid", 32'(dig_valid), 32'h3F);
        check("t2_short_hold_pulses", 32'(pulses), 32'd0);

        // 3: illegal glyph, a blank, then saturation of the error count
        expect_latch(2, 7'h55);
        hold(6'b000100, 7'h55, 5, first, pulses);
        check("t3_err",   32'(dig_err), 32'b000100);
        check("t3_hex",   32'(hex_out), 32'hFEBA70);
        expect_latch(3, 7'h7F);
        hold(6'b001000, 7'h7F, 5, first, pulses);
        check("t4_blank_hex",   32'(hex_out), 32'hFE0A70);
        check("t4_blank_count", 32'(err_count), 32'd1);
        for (int r = 0; r < 300; r++) begin
            s = r[0] ? 7'h55 : 7'h2A;
            expect_latch(2, s);
            hold(6'b000100, s, 5, first, pulses);
        end
        check("t3_saturate", 32'(err_count), 32'd255);

        // 4: multi-hot and empty strobes never latch
        hold(6'b000011, 7'h24, 10, first, pulses);
        check("t4_multihot_pulses", 32'(pulses), 32'd0);
        hold(6'b000000, 7'h24, 10, first, pulses);
        check("t4_empty_pulses", 32'(pulses), 32'd0);
        check("t4_valid", 32'(dig_valid), 32'b110011);

        // 5: change mid-hold restarts the window
        hold(6'b000010, 7'h30, 3, first, pulses);
        check("t5_early_pulses", 32'(pulses), 32'd0);
        expect_latch(1, 7'h19);
        hold(6'b000010, 7'h19, 6, first, pulses);
        check("t5_latency", 32'(first), 32'd5);
        check("t5_pulses",  32'(pulses), 32'd1);

        // 6a: reset mid-TRACK, then a full window
        hold(6'b000100, 7'h30, 2, first, pulses);
        resetn = 1'b0;
        @(negedge clock);
        check_all_zero("t6_reset");
        resetn = 1'b1;
        model_reset();
        expect_latch(2, 7'h30);
        hold(6'b000100, 7'h30, 6, first, pulses);
        check("t6_reset_latency", 32'(first), 32'd5);

        // 6b: clear coincident with the latch edge
        hold(6'b000001, 7'h79, 4, first, pulses);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check_all_zero("t6_clear");
        model_reset();
        expect_latch(0, 7'h79);
        hold(6'b000001, 7'h79, 6, first, pulses);
        check("t6_clear_relatch", 32'(first), 32'd4);

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
